// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and nibble clamp helper for the bcd_counter_n family.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: loads a clamped nibble, or steps up/down on ci and
// signals carry/borrow on co when the step wraps this digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ci,
    input  logic       up,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t value,
    output logic       co
);

    bcd_digit_t value_reg;
    bcd_digit_t value_next;
    logic       at_bound;

    assign at_bound = up ? (value_reg == BCD_MAX) : (value_reg == BCD_MIN);
    assign co       = ci & at_bound;
    assign value    = value_reg;

    always_comb begin
        value_next = value_reg;
        if (load) begin
            value_next = bcd_clamp(load_digit);
        end else if (ci) begin
            if (up) begin
                value_next = at_bound ? BCD_MIN : value_reg + 4'd1;
            end else begin
                value_next = at_bound ? BCD_MAX : value_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg <= BCD_MIN;
        end else begin
            value_reg <= value_next;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit up/down BCD counter with validated load and cascadable tc.
// Define BCD_CNT_SAT_EN to saturate at the bounds and add the sat output.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err
`ifdef BCD_CNT_SAT_EN
    ,
    output logic                  sat
`endif
);

    logic [DIGITS-1:0] ci;
    logic [DIGITS-1:0] co;
    logic [DIGITS-1:0] nib_bad;
    logic              step;
    logic              load_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .ci         (ci[gi]),
                .up         (up),
                .load       (load),
                .load_digit (load_val[DIGIT_W*gi +: DIGIT_W]),
                .value      (count[DIGIT_W*gi +: DIGIT_W]),
                .co         (co[gi])
            );
            assign nib_bad[gi] = (load_val[DIGIT_W*gi +: DIGIT_W] > BCD_MAX);
            if (gi == 0) begin : g_first
                assign ci[gi] = step;
            end else begin : g_chain
                assign ci[gi] = co[gi-1];
            end
        end
    endgenerate

`ifdef BCD_CNT_SAT_EN
    logic at_bound;
    logic sat_hold;
    logic sat_reg;

    assign at_bound = up ? (count == {DIGITS{BCD_MAX}}) : (count == {DIGITS{BCD_MIN}});
    assign sat_hold = en & at_bound;
    // Suppressing the step at a bound keeps every digit still; tc then comes from sat_hold.
    assign step     = en & ~sat_hold;
    assign tc       = ~load & (co[DIGITS-1] | sat_hold);
    assign sat      = sat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_reg <= 1'b0;
        end else begin
            sat_reg <= ~load & sat_hold;
        end
    end
`else
    // The top digit's carry is exactly "enabled and every digit at its bound".
    assign step = en;
    assign tc   = ~load & co[DIGITS-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err_reg <= 1'b0;
        end else begin
            load_err_reg <= load & (|nib_bad);
        end
    end

    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n (DIGITS=2) plus a two-instance cascade.
module tb_bcd_counter_n;

    logic       clk;
    logic       rst, en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc, load_err;

    logic       c_rst, c_en, c_up, c_load;
    logic [7:0] lo_count, hi_count;
    logic       lo_tc, hi_tc, lo_err, hi_err;

`ifdef BCD_CNT_SAT_EN
    logic sat, lo_sat, hi_sat;
`endif

    int n_cmp;
    int n_bad;
    int model;

    bcd_counter_n #(.DIGITS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .load_err(load_err)
`ifdef BCD_CNT_SAT_EN
        , .sat(sat)
`endif
    );

    bcd_counter_n #(.DIGITS(2)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load), .load_val(8'h00),
        .count(lo_count), .tc(lo_tc), .load_err(lo_err)
`ifdef BCD_CNT_SAT_EN
        , .sat(lo_sat)
`endif
    );

    bcd_counter_n #(.DIGITS(2)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(c_up), .load(c_load), .load_val(8'h00),
        .count(hi_count), .tc(hi_tc), .load_err(hi_err)
`ifdef BCD_CNT_SAT_EN
        , .sat(hi_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int model_up(input int v);
`ifdef BCD_CNT_SAT_EN
        return (v == 99) ? 99 : v + 1;
`else
        return (v + 1) % 100;
`endif
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        c_rst = 1'b1; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0;
        #1;

        // Reset overrides load and en
        load = 1'b1; load_val = 8'h37;
        step();
        check("pre_load_37", 32'(count), 32'h37);
        rst = 1'b1; en = 1'b1;
        step();
        check("rst_count", 32'(count), 32'h00);
        check("rst_load_err", 32'(load_err), 32'h0);
        rst = 1'b0; load = 1'b0; up = 1'b1;
        #1;
        check("rst_tc_up", 32'(tc), 32'h0);
        step();
        check("after_rst_01", 32'(count), 32'h01);

        // Up count through every decade and the 99 wrap
        load = 1'b1; load_val = 8'h00;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        model = 0;
        #1;
        for (int i = 0; i < 100; i++) begin
            check("up_tc", 32'(tc), (model == 99) ? 32'h1 : 32'h0);
            step();
            model = model_up(model);
            check("up_count", 32'(count), 32'(to_bcd(model)));
        end

        // Down count with borrow
        load = 1'b1; load_val = 8'h10;
        step();
        check("load_10", 32'(count), 32'h10);
        load = 1'b0; up = 1'b0;
        step();
        check("down_09", 32'(count), 32'h09);
        step();
        check("down_08", 32'(count), 32'h08);
        load = 1'b1; load_val = 8'h00;
        step();
        load = 1'b0;
        #1;
        check("down_tc_at_00", 32'(tc), 32'h1);
        step();
`ifdef BCD_CNT_SAT_EN
        check("down_sat_hold", 32'(count), 32'h00);
        check("down_sat_flag", 32'(sat), 32'h1);
`else
        check("down_wrap_99", 32'(count), 32'h99);
`endif

        // Load priority and BCD validation
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 8'h5C;
        step();
        check("load_5C_count", 32'(count), 32'h59);
        check("load_5C_err", 32'(load_err), 32'h1);
        load_val = 8'h42;
        step();
        check("load_42_count", 32'(count), 32'h42);
        check("load_42_err", 32'(load_err), 32'h0);
        load_val = 8'hF3;
        step();
        check("load_F3_count", 32'(count), 32'h93);
        load = 1'b0; en = 1'b0;
        step();
        check("err_clears", 32'(load_err), 32'h0);
        check("hold_after_load", 32'(count), 32'h93);

        // Enable gating and direction change
        load = 1'b1; load_val = 8'h45;
        step();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gate_hold", 32'(count), 32'h45);
            check("gate_tc", 32'(tc), 32'h0);
        end
        en = 1'b1; up = 1'b1;
        step();
        check("dir_up_46", 32'(count), 32'h46);
        up = 1'b0;
        step();
        check("dir_down_45", 32'(count), 32'h45);
        step();
        check("dir_down_44", 32'(count), 32'h44);
        en = 1'b0;

        // Cascade: upper en driven by lower tc
        step();
        c_rst = 1'b0; c_en = 1'b1; c_up = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
        end
        c_en = 1'b0;
`ifdef BCD_CNT_SAT_EN
        check("casc_lo", 32'(lo_count), 32'h99);
        check("casc_hi", 32'(hi_count), 32'h51);
`else
        check("casc_lo", 32'(lo_count), 32'h50);
        check("casc_hi", 32'(hi_count), 32'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
